// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b datapath types plus the L1-to-L2 arbiter types.
//   lc3b_word       16-bit word / address
//   lc3b_line       128-bit cache line
//   l2_arb_state_t  arbiter FSM state
//   l2_arb_owner_t  which L1 master owns (or last owned) the L2 port
//   l2_arb_pick()   round-robin winner selection for the arbitration slots
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2,
    ARB_RELEASE = 2'd3
  } l2_arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } l2_arb_owner_t;

  // On contention the master that did not win last time gets the port;
  // otherwise the sole requester wins. Only meaningful when a request exists.
  function automatic l2_arb_owner_t l2_arb_pick(input logic req_i,
                                                input logic req_d,
                                                input l2_arb_owner_t last);
    l2_arb_owner_t pick;
    if (req_i && req_d) begin
      pick = (last == ICACHE) ? DCACHE : ICACHE;
    end else if (req_i) begin
      pick = ICACHE;
    end else begin
      pick = DCACHE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/l2_arbiter_sat_counter.sv
// l2_arb_sat_counter: saturating up-counter for arbiter performance monitoring.
//   clk    clock
//   rst_n  asynchronous active-low reset (count -> 0)
//   clr    synchronous clear, wins over a same-cycle increment
//   inc    increment request; ignored once the count is all-ones
//   count  current value
module l2_arb_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_r;

  // Counter register: clear first, then saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin arbiter sharing the L1-to-L2 wishbone port between
// the icache and dcache. A grant is held for the whole transaction and every
// termination (ack, rty or master abort) is followed by a one-cycle release
// slot, which doubles as an arbitration slot.
//   icache_* / dcache_*    L1 master request side (cyc/stb/we/adr/sel/dat_m in,
//                          ack/rty out)
//   l1_dat_s               L2 read data broadcast to both masters
//   l2_*                   L2 slave side (cyc/stb/we/adr/sel/dat_m out,
//                          ack/rty/dat_s in)
//   cnt_clear              synchronous clear of the performance counters
//   icache_grants, dcache_grants, conflict_events  saturating counters
module l2_arbiter
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 icache_cyc,
  input  logic                 icache_stb,
  input  logic                 icache_we,
  input  lc3b_word             icache_adr,
  input  logic [15:0]          icache_sel,
  input  lc3b_line             icache_dat_m,
  output logic                 icache_ack,
  output logic                 icache_rty,
  input  logic                 dcache_cyc,
  input  logic                 dcache_stb,
  input  logic                 dcache_we,
  input  lc3b_word             dcache_adr,
  input  logic [15:0]          dcache_sel,
  input  lc3b_line             dcache_dat_m,
  output logic                 dcache_ack,
  output logic                 dcache_rty,
  output lc3b_line             l1_dat_s,
  output logic                 l2_cyc,
  output logic                 l2_stb,
  output logic                 l2_we,
  output lc3b_word             l2_adr,
  output logic [15:0]          l2_sel,
  output lc3b_line             l2_dat_m,
  input  logic                 l2_ack,
  input  logic                 l2_rty,
  input  lc3b_line             l2_dat_s,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] icache_grants,
  output logic [CNT_WIDTH-1:0] dcache_grants,
  output logic [CNT_WIDTH-1:0] conflict_events
);

  l2_arb_state_t state_r;
  l2_arb_state_t state_nxt_s;
  l2_arb_owner_t last_grant_r;
  l2_arb_owner_t last_grant_nxt_s;
  l2_arb_owner_t winner_s;
  logic          req_i_s;
  logic          req_d_s;
  logic          inc_i_s;
  logic          inc_d_s;
  logic          inc_conf_s;

  assign req_i_s  = icache_cyc & icache_stb;
  assign req_d_s  = dcache_cyc & dcache_stb;
  assign l1_dat_s = l2_dat_s;

  // Next-state logic; IDLE and RELEASE share the same arbitration rules.
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    winner_s         = l2_arb_pick(req_i_s, req_d_s, last_grant_r);
    inc_i_s          = 1'b0;
    inc_d_s          = 1'b0;
    inc_conf_s       = 1'b0;
    case (state_r)
      ARB_IDLE, ARB_RELEASE: begin
        if (req_i_s || req_d_s) begin
          state_nxt_s      = (winner_s == ICACHE) ? ARB_GRANT_I : ARB_GRANT_D;
          last_grant_nxt_s = winner_s;
          inc_i_s          = (winner_s == ICACHE);
          inc_d_s          = (winner_s == DCACHE);
          inc_conf_s       = req_i_s & req_d_s;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      // A termination or a dropped request (abort) both end the grant; any
      // new request seen at this edge waits for the release slot.
      ARB_GRANT_I: begin
        if (l2_ack || l2_rty || !req_i_s) begin
          state_nxt_s = ARB_RELEASE;
        end else begin
          state_nxt_s = ARB_GRANT_I;
        end
      end
      ARB_GRANT_D: begin
        if (l2_ack || l2_rty || !req_d_s) begin
          state_nxt_s = ARB_RELEASE;
        end else begin
          state_nxt_s = ARB_GRANT_D;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // FSM and round-robin history registers; dcache counts as last owner after
  // reset so icache wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ARB_IDLE;
      last_grant_r <= DCACHE;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
    end
  end

  // Combinational bus steering: owner's request to L2, L2 termination to owner.
  always_comb begin
    l2_cyc     = 1'b0;
    l2_stb     = 1'b0;
    l2_we      = 1'b0;
    l2_adr     = 16'h0000;
    l2_sel     = 16'h0000;
    l2_dat_m   = 128'h0;
    icache_ack = 1'b0;
    icache_rty = 1'b0;
    dcache_ack = 1'b0;
    dcache_rty = 1'b0;
    case (state_r)
      ARB_GRANT_I: begin
        l2_cyc     = icache_cyc;
        l2_stb     = icache_stb;
        l2_we      = icache_we;
        l2_adr     = icache_adr;
        l2_sel     = icache_sel;
        l2_dat_m   = icache_dat_m;
        icache_ack = l2_ack;
        icache_rty = l2_rty;
      end
      ARB_GRANT_D: begin
        l2_cyc     = dcache_cyc;
        l2_stb     = dcache_stb;
        l2_we      = dcache_we;
        l2_adr     = dcache_adr;
        l2_sel     = dcache_sel;
        l2_dat_m   = dcache_dat_m;
        dcache_ack = l2_ack;
        dcache_rty = l2_rty;
      end
      default: begin
        l2_cyc = 1'b0;
      end
    endcase
  end

  l2_arb_sat_counter #(.WIDTH(CNT_WIDTH)) u_icache_grants (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clear),
    .inc   (inc_i_s),
    .count (icache_grants)
  );

  l2_arb_sat_counter #(.WIDTH(CNT_WIDTH)) u_dcache_grants (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clear),
    .inc   (inc_d_s),
    .count (dcache_grants)
  );

  l2_arb_sat_counter #(.WIDTH(CNT_WIDTH)) u_conflict_events (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clear),
    .inc   (inc_conf_s),
    .count (conflict_events)
  );

endmodule

// File: tb/tb_l2_arbiter.sv
// Testbench for l2_arbiter: transaction rounds from both L1 masters against a
// randomly delayed L2 slave; expected grants are queued at issue time by a
// round-robin transaction model and checked by an independent monitor.
module tb_l2_arbiter;

  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          icache_cyc, icache_stb, icache_we, icache_ack, icache_rty;
  logic [15:0]   icache_adr, icache_sel;
  logic [127:0]  icache_dat_m;
  logic          dcache_cyc, dcache_stb, dcache_we, dcache_ack, dcache_rty;
  logic [15:0]   dcache_adr, dcache_sel;
  logic [127:0]  dcache_dat_m;
  logic [127:0]  l1_dat_s;
  logic          l2_cyc, l2_stb, l2_we, l2_ack, l2_rty;
  logic [15:0]   l2_adr, l2_sel;
  logic [127:0]  l2_dat_m, l2_dat_s;
  logic          cnt_clear;
  logic [CW-1:0] icache_grants, dcache_grants, conflict_events;

  l2_arbiter #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_cyc(icache_cyc), .icache_stb(icache_stb), .icache_we(icache_we),
    .icache_adr(icache_adr), .icache_sel(icache_sel), .icache_dat_m(icache_dat_m),
    .icache_ack(icache_ack), .icache_rty(icache_rty),
    .dcache_cyc(dcache_cyc), .dcache_stb(dcache_stb), .dcache_we(dcache_we),
    .dcache_adr(dcache_adr), .dcache_sel(dcache_sel), .dcache_dat_m(dcache_dat_m),
    .dcache_ack(dcache_ack), .dcache_rty(dcache_rty),
    .l1_dat_s(l1_dat_s),
    .l2_cyc(l2_cyc), .l2_stb(l2_stb), .l2_we(l2_we), .l2_adr(l2_adr),
    .l2_sel(l2_sel), .l2_dat_m(l2_dat_m),
    .l2_ack(l2_ack), .l2_rty(l2_rty), .l2_dat_s(l2_dat_s),
    .cnt_clear(cnt_clear),
    .icache_grants(icache_grants), .dcache_grants(dcache_grants),
    .conflict_events(conflict_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    bit           owner;
    bit           we;
    logic [15:0]  adr;
    logic [15:0]  sel;
    logic [127:0] dat;
  } txn_t;

  txn_t exp_q[$];
  int   start_q[$];
  int   term_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // master / slave / model state
  bit   m_act[2];
  bit   m_stb[2];
  bit   m_term[2];
  int   m_abort[2];
  txn_t m_txn[2];
  bit   stb_seen, slave_hold, clr_next;
  int   slave_wait;
  int   gi, gd, gc;
  bit   last_w;
  bit   cyc_prev, cur_owner;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic drive_masters();
    icache_cyc   = m_act[0];
    icache_stb   = m_act[0] & m_stb[0];
    icache_we    = m_txn[0].we;
    icache_adr   = m_txn[0].adr;
    icache_sel   = m_txn[0].sel;
    icache_dat_m = m_txn[0].dat;
    dcache_cyc   = m_act[1];
    dcache_stb   = m_act[1] & m_stb[1];
    dcache_we    = m_txn[1].we;
    dcache_adr   = m_txn[1].adr;
    dcache_sel   = m_txn[1].sel;
    dcache_dat_m = m_txn[1].dat;
  endtask

  // One clock: drive just after posedge, observe at negedge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (m_act[m] && (m_term[m] || !m_stb[m])) m_act[m] = 1'b0;
      else if (m_act[m] && m_abort[m] == 1) m_stb[m] = 1'b0;
      if (m_abort[m] > 0) m_abort[m]--;
      m_term[m] = 1'b0;
    end
    if (l2_ack || l2_rty) begin
      l2_ack = 1'b0;
      l2_rty = 1'b0;
    end else if (stb_seen && !slave_hold) begin
      if (slave_wait == 0) begin
        if ($urandom_range(0, 3) == 0) l2_rty = 1'b1;
        else l2_ack = 1'b1;
      end else begin
        slave_wait--;
      end
    end
    cnt_clear = clr_next;
    clr_next  = 1'b0;
    l2_dat_s  = {$urandom(), $urandom(), $urandom(), $urandom()};
    drive_masters();
    @(negedge clk);
    if (icache_ack || icache_rty) m_term[0] = 1'b1;
    if (dcache_ack || dcache_rty) m_term[1] = 1'b1;
    if (l2_stb && !stb_seen) slave_wait = $urandom_range(0, 3);
    stb_seen = l2_stb;
  endtask

  // Monitor: pops the expected grant on each new L2 cycle, checks steering.
  initial begin : monitor
    txn_t e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        cyc_prev = 1'b0;
      end else begin
        check("l1_dat_s", l1_dat_s, l2_dat_s);
        if (l2_cyc && !cyc_prev) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL grant_unexpected: got grant adr %0h, expected no grant (cycle %0d)", l2_adr, cyc_n);
          end else begin
            e = exp_q.pop_front();
            cur_owner = e.owner;
            start_q.push_back(cyc_n);
            check("grant_adr", l2_adr, e.adr);
            check("grant_we", l2_we, e.we);
            check("grant_sel", l2_sel, e.sel);
            check("grant_dat_m", l2_dat_m, e.dat);
            check("grant_stb", l2_stb, 1'b1);
          end
        end
        if (l2_cyc) begin
          check("icache_ack", icache_ack, (cur_owner == 1'b0) ? l2_ack : 1'b0);
          check("icache_rty", icache_rty, (cur_owner == 1'b0) ? l2_rty : 1'b0);
          check("dcache_ack", dcache_ack, (cur_owner == 1'b1) ? l2_ack : 1'b0);
          check("dcache_rty", dcache_rty, (cur_owner == 1'b1) ? l2_rty : 1'b0);
          if (l2_ack || l2_rty) term_q.push_back(cyc_n);
        end else begin
          check("idle_ctl", {l2_stb, l2_we, icache_ack, icache_rty, dcache_ack, dcache_rty, l2_adr, l2_sel}, 128'h0);
          check("idle_dat_m", l2_dat_m, 128'h0);
        end
        cyc_prev = l2_cyc;
      end
    end
  end

  // mode bit0 = icache requests, bit1 = dcache requests (same cycle)
  task automatic run_round(input int mode, input bit clr, input int abort_steps, input bit hold);
    int issue;
    int n_exp;
    bit w;
    for (int m = 0; m < 2; m++) begin
      if (mode[m]) begin
        m_txn[m].owner = m[0];
        m_txn[m].adr   = {m[0], 15'($urandom())};
        m_txn[m].sel   = 16'($urandom());
        m_txn[m].dat   = {$urandom(), $urandom(), $urandom(), $urandom()};
        m_txn[m].we    = 1'($urandom_range(0, 1));
        m_act[m]       = 1'b1;
        m_stb[m]       = 1'b1;
        m_abort[m]     = (m == 0) ? abort_steps : 0;
      end
    end
    if (mode == 3) begin
      w = ~last_w;
      exp_q.push_back(m_txn[w]);
      exp_q.push_back(m_txn[~w]);
      gc = sat(gc + 1);
      gi = sat(gi + 1);
      gd = sat(gd + 1);
      last_w = ~w;
      n_exp = 2;
    end else begin
      w = (mode == 2);
      exp_q.push_back(m_txn[w]);
      if (w) gd = sat(gd + 1);
      else gi = sat(gi + 1);
      last_w = w;
      n_exp = 1;
    end
    if (clr) begin
      gi = 0;
      gd = 0;
      gc = 0;
    end
    slave_hold = hold;
    clr_next   = clr;
    step();
    issue = cyc_n;
    for (int k = 0; k < 80 && (m_act[0] || m_act[1]); k++) step();
    if (m_act[0] || m_act[1]) begin
      n_cmp++;
      n_err++;
      $display("FAIL round_timeout: got masters still active after 80 cycles, expected all done");
      m_act[0] = 1'b0;
      m_act[1] = 1'b0;
    end
    step();
    step();
    slave_hold = 1'b0;
    check("round_queue_empty", exp_q.size(), 0);
    check("round_grants", start_q.size(), n_exp);
    if (start_q.size() > 0) check("grant_latency", start_q[0] - issue, 1);
    if (n_exp == 2 && start_q.size() == 2 && term_q.size() > 0)
      check("release_gap", start_q[1] - term_q[0], 2);
    check("icache_grants", icache_grants, gi);
    check("dcache_grants", dcache_grants, gd);
    check("conflict_events", conflict_events, gc);
    exp_q.delete();
    start_q.delete();
    term_q.delete();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    rst_n = 1'b0;
    l2_ack = 1'b0;
    l2_rty = 1'b0;
    l2_dat_s = 128'h0;
    cnt_clear = 1'b0;
    clr_next = 1'b0;
    slave_hold = 1'b0;
    stb_seen = 1'b0;
    slave_wait = 0;
    gi = 0; gd = 0; gc = 0;
    last_w = 1'b1;
    for (int m = 0; m < 2; m++) begin
      m_act[m] = 1'b0; m_stb[m] = 1'b0; m_term[m] = 1'b0; m_abort[m] = 0;
      m_txn[m] = '{owner: m[0], we: 1'b1, adr: 16'hFFFF, sel: 16'hFFFF, dat: '1};
    end
    drive_masters();
    step();
    step();
    check("reset_l2_cyc", l2_cyc, 1'b0);
    check("reset_counters", {icache_grants, dcache_grants, conflict_events}, 128'h0);
    rst_n = 1'b1;
    step();

    // first conflict goes to icache, then sustained alternation
    for (int r = 0; r < 3; r++) run_round(3, 1'b0, 0, 1'b0);
    check("sustained_icache", icache_grants, 3);
    check("sustained_dcache", dcache_grants, 3);

    // icache abort: stb dropped mid-grant, slave never terminates
    run_round(1, 1'b0, 4, 1'b1);

    for (int r = 0; r < 30; r++) run_round($urandom_range(1, 3), 1'b0, 0, 1'b0);

    for (int r = 0; r < 17; r++) run_round(1, 1'b0, 0, 1'b0);
    check("sat_icache", icache_grants, SAT);

    // clear coincides with a grant edge: clear wins
    run_round(1, 1'b1, 0, 1'b0);
    check("clear_icache", icache_grants, 0);

    // reset in the second grant cycle
    m_txn[0].adr = {1'b0, 15'($urandom())};
    m_act[0] = 1'b1;
    m_stb[0] = 1'b1;
    m_abort[0] = 0;
    exp_q.push_back(m_txn[0]);
    slave_hold = 1'b1;
    step();
    step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_l2_cyc", {l2_cyc, l2_stb}, 2'b00);
    check("midrst_acks", {icache_ack, dcache_ack}, 2'b00);
    check("midrst_counters", {icache_grants, dcache_grants, conflict_events}, 128'h0);
    m_act[0] = 1'b0;
    m_act[1] = 1'b0;
    exp_q.delete();
    start_q.delete();
    term_q.delete();
    gi = 0; gd = 0; gc = 0;
    last_w = 1'b1;
    slave_hold = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    run_round(3, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
